muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request from control unit, sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 A_in  input  32  multiplicand or dividend, captured when start is accepted.
REQ-007 B_in  input  32  multiplier or divisor, captured when start is accepted.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; HI_out and LO_out are valid from this cycle on.
REQ-010 div_zero  output  1  high with done when a divide had B_in = 0.
REQ-011 HI_out  output  32  high product word or remainder, held until the next done.
REQ-012 LO_out  output  32  low product word or quotient, held until the next done.

Function
REQ-013 The block SHALL use states IDLE, LOAD, RUN, FIX and DONE.
REQ-014 The block SHALL leave IDLE for LOAD only on start=1 while in IDLE, capturing op, A_in and B_in.
- Start at any other time SHALL be ignored.
REQ-015 LOAD SHALL make operands absolute, record the result signs, clear the iteration counter, and go to RUN.
REQ-016 RUN SHALL perform exactly 32 iterations, one per cycle.
- Multiply: shift-add on magnitudes into a 64-bit accumulator.
- Divide: restoring division on magnitudes.
REQ-017 When the counter reaches 31, RUN SHALL go to FIX.
- FIX applies sign correction and goes to DONE.
- DONE drives done=1 and returns to IDLE.
REQ-018 done SHALL rise exactly 35 rising edges after the edge that accepted start.
- busy SHALL be high from edge +1 through edge +35 inclusive.
REQ-019 Multiply SHALL give {HI_out,LO_out} = the full signed 64-bit product of A_in and B_in.
REQ-020 Divide SHALL give LO_out = the quotient truncated toward zero, and HI_out = the remainder with the sign of the dividend.
REQ-021 Divide 0x80000000 / 0xFFFFFFFF SHALL give LO_out=0x80000000, HI_out=0, with no flag.
REQ-022 Divide with B_in=0 SHALL go LOAD -> DONE directly.
- done and div_zero are high in that DONE cycle.
- HI_out and LO_out keep their previous values.
REQ-023 HI_out and LO_out SHALL update only on the edge entering DONE; intermediate values SHALL never appear on them.
REQ-024 div_zero SHALL be low in every cycle where done is low.

Reset
REQ-025 On reset assertion, regardless of state, the block SHALL go to IDLE immediately.
- Any operation in progress is abandoned, with no done pulse.
REQ-026 Reset values SHALL be busy=0, done=0, div_zero=0, HI_out=0, LO_out=0, and all internal registers 0.
REQ-027 After reset deasserts, the first start SHALL be accepted on the next rising edge with start=1.

Configuration
REQ-028 The macro MULDIV_DIV_EN SHALL control whether divide support is compiled in.
- Defined: divide is present as specified above.
- Undefined: divide hardware is absent, div_zero is tied 0, and a start with op=1 is ignored (block stays IDLE, busy=0). Multiply behaviour and timing are unchanged.

Structure
REQ-029 A shared package muldiv_pkg SHALL hold the following.
- State encoding: IDLE=0, LOAD=1, RUN=2, FIX=3, DONE=4 (3 bits).
- Op encoding constants OP_MULT=0 and OP_DIV=1.
- MULDIV_ITER=32.
- Operand width 32.
REQ-030 One combinational sub-module, muldiv_step, SHALL compute a single multiply or divide iteration.
- muldiv_ctrl holds all state and the counter.

Verification
REQ-031 MULT 7 x -3 -> done at edge +35, HI_out=0xFFFFFFFF, LO_out=0xFFFFFFEB, div_zero=0.
REQ-032 DIV -7 / 2 -> LO_out=0xFFFFFFFD, HI_out=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO_out=0x80000000, HI_out=0.
REQ-033 DIV 5 / 0 after a prior result of HI=1, LO=2 -> done and div_zero at edge +2, HI_out=1, LO_out=2.
REQ-034 Start pulsed at cycles +5 and +20 during a MULT of 0xFFFFFFFF x 0xFFFFFFFF -> both ignored; a single done with HI_out=0, LO_out=1.
REQ-035 Reset asserted at cycle +10 of a MULT -> outputs 0 and busy 0 at once, no done pulse; a new MULT 2 x 3 then gives LO_out=6.
REQ-036 With MULDIV_DIV_EN undefined: start with op=1 -> busy stays 0 and no done pulse; a following MULT 4 x 4 gives LO_out=16.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, state/op encodings and helpers for the iterative multiply/divide controller.
package muldiv_pkg;

  localparam int MULDIV_W    = 32;
  localparam int MULDIV_ITER = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [MULDIV_W-1:0] abs_w(input logic [MULDIV_W-1:0] v);
    return v[MULDIV_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply step or one restoring-divide step on unsigned magnitudes.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic                op,
`endif
  input  logic [MULDIV_W-1:0] hi,
  input  logic [MULDIV_W-1:0] lo,
  input  logic [MULDIV_W-1:0] b_mag,
  output logic [MULDIV_W-1:0] hi_next,
  output logic [MULDIV_W-1:0] lo_next
);

  logic [MULDIV_W:0] mul_sum;
  // Multiplier bits sit in lo and are consumed LSB first while the sum shifts in from the top.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : {(MULDIV_W+1){1'b0}});

`ifdef MULDIV_DIV_EN
  logic [MULDIV_W:0] div_shift;
  logic [MULDIV_W:0] div_diff;
  // Remainder in hi, dividend bits shift out of lo MSB first while quotient bits shift in.
  assign div_shift = {hi, lo[MULDIV_W-1]};
  assign div_diff  = div_shift - {1'b0, b_mag};
`endif

  always_comb begin
    hi_next = mul_sum[MULDIV_W:1];
    lo_next = {mul_sum[0], lo[MULDIV_W-1:1]};
`ifdef MULDIV_DIV_EN
    if (op == OP_DIV) begin
      if (!div_diff[MULDIV_W]) begin
        hi_next = div_diff[MULDIV_W-1:0];
        lo_next = {lo[MULDIV_W-2:0], 1'b1};
      end else begin
        hi_next = div_shift[MULDIV_W-1:0];
        lo_next = {lo[MULDIV_W-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative signed 32x32 multiply / 32/32 divide controller (IDLE-LOAD-RUN-FIX-DONE).
// Define MULDIV_DIV_EN to compile in divide support; without it op=1 starts are ignored.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [MULDIV_W-1:0] A_in,
  input  logic [MULDIV_W-1:0] B_in,
  output logic                busy,
  output logic                done,
  output logic                div_zero,
  output logic [MULDIV_W-1:0] HI_out,
  output logic [MULDIV_W-1:0] LO_out
);

  localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITER - 1);

  state_t                state_reg;
  logic [MULDIV_W-1:0]   acc_hi_reg;
  logic [MULDIV_W-1:0]   acc_lo_reg;
  logic [MULDIV_W-1:0]   b_mag_reg;
  logic [4:0]            cnt_reg;
  logic                  sign_a_reg;
  logic                  sign_b_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [MULDIV_W-1:0]   hi_out_reg;
  logic [MULDIV_W-1:0]   lo_out_reg;

  logic [MULDIV_W-1:0]   step_hi;
  logic [MULDIV_W-1:0]   step_lo;
  logic [MULDIV_W-1:0]   fix_hi;
  logic [MULDIV_W-1:0]   fix_lo;
  logic [2*MULDIV_W-1:0] neg_prod;
  logic                  accept;

`ifdef MULDIV_DIV_EN
  logic                  op_reg;
  logic                  dz_reg;
  logic                  div_zero_reg;

  assign accept = start;
`else
  assign accept = start && (op == OP_MULT);
`endif

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .op      (op_reg),
`endif
    .hi      (acc_hi_reg),
    .lo      (acc_lo_reg),
    .b_mag   (b_mag_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  assign neg_prod = -{acc_hi_reg, acc_lo_reg};

  always_comb begin
    fix_hi = (sign_a_reg ^ sign_b_reg) ? neg_prod[2*MULDIV_W-1:MULDIV_W] : acc_hi_reg;
    fix_lo = (sign_a_reg ^ sign_b_reg) ? neg_prod[MULDIV_W-1:0] : acc_lo_reg;
`ifdef MULDIV_DIV_EN
    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    if (op_reg == OP_DIV) begin
      fix_lo = (sign_a_reg ^ sign_b_reg) ? -acc_lo_reg : acc_lo_reg;
      fix_hi = sign_a_reg ? -acc_hi_reg : acc_hi_reg;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      b_mag_reg    <= '0;
      cnt_reg      <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_out_reg   <= '0;
      lo_out_reg   <= '0;
`ifdef MULDIV_DIV_EN
      op_reg       <= 1'b0;
      dz_reg       <= 1'b0;
      div_zero_reg <= 1'b0;
`endif
    end else begin
      // Status outputs are registered from the state, so they trail it by one cycle.
      busy_reg <= (state_reg != IDLE);
      done_reg <= (state_reg == DONE);
`ifdef MULDIV_DIV_EN
      div_zero_reg <= (state_reg == DONE) && dz_reg;
`endif
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_lo_reg <= A_in;
            b_mag_reg  <= B_in;
`ifdef MULDIV_DIV_EN
            op_reg     <= op;
            dz_reg     <= 1'b0;
`endif
            state_reg  <= LOAD;
          end
        end
        LOAD: begin
          sign_a_reg <= acc_lo_reg[MULDIV_W-1];
          sign_b_reg <= b_mag_reg[MULDIV_W-1];
          acc_lo_reg <= abs_w(acc_lo_reg);
          b_mag_reg  <= abs_w(b_mag_reg);
          acc_hi_reg <= '0;
          cnt_reg    <= '0;
          state_reg  <= RUN;
`ifdef MULDIV_DIV_EN
          if ((op_reg == OP_DIV) && (b_mag_reg == '0)) begin
            dz_reg    <= 1'b1;
            state_reg <= DONE;
          end
`endif
        end
        RUN: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          cnt_reg    <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_ITER) state_reg <= FIX;
        end
        FIX: begin
          hi_out_reg <= fix_hi;
          lo_out_reg <= fix_lo;
          state_reg  <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign HI_out = hi_out_reg;
  assign LO_out = lo_out_reg;
`ifdef MULDIV_DIV_EN
  assign div_zero = div_zero_reg;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected results computed with plain
// signed arithmetic, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] A_in = '0;
  logic [31:0] B_in = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI_out;
  logic [31:0] LO_out;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  muldiv_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A_in     (A_in),
    .B_in     (B_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HI_out   (HI_out),
    .LO_out   (LO_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          $display("txn done cyc=%0d HI=%h LO=%h dz=%b", cyc, HI_out, LO_out, div_zero);
          chk("hi_out", 64'(HI_out), 64'(e.hi));
          chk("lo_out", 64'(LO_out), 64'(e.lo));
          chk("div_zero", 64'(div_zero), 64'(e.dz));
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
      if (div_zero && !done) chk("div_zero_without_done", 64'(div_zero), 64'd0);
    end
  end

  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit noise);
    exp_t   e;
    int     acc;
    int     t;
    int     lat;
    bit     exec;
    longint pa;
    longint pb;
    longint r64;
    longint q64;
    exec = 1'b1;
`ifndef MULDIV_DIV_EN
    if (o) exec = 1'b0;
`endif
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (!o) begin
      r64 = pa * pb;
      e.hi = r64[63:32]; e.lo = r64[31:0]; e.dz = 1'b0; lat = 35;
    end else if (b == 32'd0) begin
      e.hi = prev_hi; e.lo = prev_lo; e.dz = 1'b1; lat = 2;
    end else begin
      q64 = pa / pb;
      r64 = pa % pb;
      e.hi = r64[31:0]; e.lo = q64[31:0]; e.dz = 1'b0; lat = 35;
    end
    @(negedge clock);
    start = 1'b1; op = o; A_in = a; B_in = b;
    @(posedge clock); #1;
    acc = cyc;
    $display("txn issue op=%0d A=%h B=%h exec=%0d", o, a, b, exec);
    if (exec) begin
      e.due = acc + lat;
      sb_q.push_back(e);
      prev_hi = e.hi;
      prev_lo = e.lo;
    end
    @(negedge clock);
    start = 1'b0; A_in = $urandom; B_in = $urandom; op = 1'($urandom);
    if (!exec) begin
      repeat (40) begin
        @(negedge clock);
        chk("ignored_busy", 64'(busy), 64'd0);
      end
      return;
    end
    @(posedge clock); #1;
    chk("busy_after_load", 64'(busy), 64'd1);
    if (noise) begin
      while (cyc < acc + 5) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      while (cyc < acc + 20) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clock);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(HI_out), 64'd0);
    chk("rst_lo", 64'(LO_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
`ifdef MULDIV_DIV_EN
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 32'd5, 32'd2, 1'b0);
    do_op(1'b1, 32'd5, 32'd0, 1'b0);
`else
    do_op(1'b1, 32'd9, 32'd3, 1'b0);
    do_op(1'b0, 32'd4, 32'd4, 1'b0);
`endif
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Abort a multiply with reset mid-flight; no done may follow.
    @(negedge clock);
    start = 1'b1; op = 1'b0; A_in = 32'd1234; B_in = 32'd5678;
    @(posedge clock); #1;
    acc = cyc;
    $display("txn issue op=0 A=%h B=%h (to be aborted)", 32'd1234, 32'd5678);
    @(negedge clock);
    start = 1'b0;
    while (cyc < acc + 10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(HI_out), 64'd0);
    chk("abort_lo", 64'(LO_out), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    do_op(1'b0, 32'd2, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), pick(), pick(), 1'($urandom_range(0, 3) == 0));
    end

    if (sb_q.size() != 0) chk("leftover_expectations", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
